// File: rtl/multicycle_control_unit.sv
// Multicycle IF/ID/EX/MEM/WB sequencer for the 16-bit TSC core.
// Optional: define INSTR_COUNT_EN to add the num_inst retired-instruction counter.
module multicycle_control_unit #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  opcode,
    input  logic [5:0]  func_code,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  imm_sel,
    output logic        alu_src_b,
    output logic        reg_write,
    output logic [1:0]  wb_src,
    output logic [1:0]  wb_dst,
    output logic        out_wwd,
    output logic        halted,
    output logic        mem_err,
    output logic [15:0] pc_init
`ifdef INSTR_COUNT_EN
    ,
    output logic [15:0] num_inst
`endif
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] imm_sel;
        logic       alu_src_b;
        logic       reg_write;
        logic [1:0] wb_src;
        logic [1:0] wb_dst;
        logic       out_wwd;
    } ctl_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_err_q, mem_err_d;
    ctl_t          ctl;

    logic       is_branch, is_wwd, is_hlt, need_mem, need_wb, dec_alu_b;
    logic [1:0] dec_pc_src, dec_imm, dec_wb_src, dec_wb_dst;

    always_comb begin
        is_branch  = 1'b0;
        is_wwd     = 1'b0;
        is_hlt     = 1'b0;
        need_mem   = 1'b0;
        need_wb    = 1'b0;
        dec_alu_b  = 1'b0;
        dec_pc_src = 2'd0;
        dec_imm    = 2'd0;
        dec_wb_src = 2'd0;
        dec_wb_dst = 2'd0;
        case (opcode)
            4'd0, 4'd1, 4'd2, 4'd3: is_branch = 1'b1;
            4'd4: begin dec_alu_b = 1'b1; need_wb = 1'b1; end
            4'd5: begin dec_alu_b = 1'b1; need_wb = 1'b1; dec_imm = 2'd1; end
            4'd6: begin dec_alu_b = 1'b1; need_wb = 1'b1; dec_imm = 2'd3; end
            4'd7: begin dec_alu_b = 1'b1; need_mem = 1'b1; need_wb = 1'b1; dec_wb_src = 2'd1; end
            4'd8: begin dec_alu_b = 1'b1; need_mem = 1'b1; end
            4'd9: begin dec_imm = 2'd2; dec_pc_src = 2'd2; end
            4'd10: begin
                dec_imm = 2'd2; dec_pc_src = 2'd2; need_wb = 1'b1;
                dec_wb_src = 2'd2; dec_wb_dst = 2'd2;
            end
            4'd15: begin
                case (func_code)
                    6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7: begin
                        need_wb = 1'b1; dec_wb_dst = 2'd1;
                    end
                    6'd25: dec_pc_src = 2'd3;
                    6'd26: begin
                        dec_pc_src = 2'd3; need_wb = 1'b1;
                        dec_wb_src = 2'd2; dec_wb_dst = 2'd2;
                    end
                    6'd28: is_wwd = 1'b1;
                    6'd29: is_hlt = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        ctl     = '0;
        state_d = state_q;
        // Decode-derived selects stay stable from ID through WB.
        if (state_q inside {S_ID, S_EX, S_MEM, S_WB}) begin
            ctl.imm_sel   = dec_imm;
            ctl.alu_src_b = dec_alu_b;
            ctl.wb_src    = dec_wb_src;
            ctl.wb_dst    = dec_wb_dst;
        end
        case (state_q)
            S_IF: begin
                ctl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctl.ir_write = 1'b1;
                    state_d      = S_ID;
                end
            end
            S_ID: state_d = is_hlt ? S_HALT : S_EX;
            S_EX: begin
                ctl.pc_write = 1'b1;
                ctl.pc_src   = is_branch ? {1'b0, br_taken} : dec_pc_src;
                ctl.out_wwd  = is_wwd;
                state_d      = need_mem ? S_MEM : (need_wb ? S_WB : S_IF);
            end
            S_MEM: begin
                ctl.mem_req = 1'b1;
                ctl.mem_we  = (opcode == 4'd8);
                if (mem_ready) state_d = need_wb ? S_WB : S_IF;
            end
            S_WB: begin
                ctl.reg_write = 1'b1;
                state_d       = S_IF;
            end
            S_HALT: ;
            default: state_d = S_IF;
        endcase
    end

    // Counter saturates at MAX_WAIT; the next stalled cycle is the one that trips mem_err.
    always_comb begin
        wait_cnt_d = '0;
        mem_err_d  = mem_err_q;
        if (ctl.mem_req && !mem_ready) begin
            if (wait_cnt_q == CW'(MAX_WAIT)) begin
                wait_cnt_d = wait_cnt_q;
                mem_err_d  = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IF;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Outputs are forced low while reset is held, even though the state already reads IF.
    assign {mem_req, mem_we, ir_write, pc_write, pc_src, imm_sel,
            alu_src_b, reg_write, wb_src, wb_dst, out_wwd} = reset_n ? ctl : '0;
    assign halted  = reset_n && (state_q == S_HALT);
    assign mem_err = mem_err_q;
    assign pc_init = PC_RESET;

`ifdef INSTR_COUNT_EN
    logic [15:0] num_inst_q, num_inst_d;
    logic        inst_done;

    assign inst_done = ((state_q inside {S_EX, S_MEM, S_WB}) && (state_d == S_IF)) ||
                       ((state_q == S_ID) && (state_d == S_HALT));

    always_comb begin
        num_inst_d = num_inst_q + {15'd0, inst_done};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) num_inst_q <= '0;
        else          num_inst_q <= num_inst_d;
    end

    assign num_inst = num_inst_q;
`endif

endmodule
